// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels and ALU-side bus of the shared ALU arbiter.
// Requester fields are packed two-wide, requester i in the upper half/slot when i=1.
interface alu_arbiter_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_use_pc;
   logic [63:0] req_a;
   logic [63:0] req_pc;
   logic [1:0]  req_use_immediate;
   logic [63:0] req_b;
   logic [63:0] req_immediate;
   logic [9:0]  req_operation;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_cnzv;
   logic        flush;
   logic        alu_use_pc;
   logic        alu_use_immediate;
   logic [31:0] alu_a;
   logic [31:0] alu_program_counter;
   logic [31:0] alu_b;
   logic [31:0] alu_immediate;
   logic [4:0]  alu_operation;
   logic [31:0] alu_result;
   logic [3:0]  alu_cnzv;
   modport slave (
      input  req_valid, req_use_pc, req_a, req_pc, req_use_immediate, req_b, req_immediate,
             req_operation, rsp_ready, flush, alu_result, alu_cnzv,
      output req_ready, rsp_valid, rsp_result, rsp_cnzv, alu_use_pc, alu_use_immediate,
             alu_a, alu_program_counter, alu_b, alu_immediate, alu_operation
   );
   modport master (
      output req_valid, req_use_pc, req_a, req_pc, req_use_immediate, req_b, req_immediate,
             req_operation, rsp_ready, flush, alu_result, alu_cnzv,
      input  req_ready, rsp_valid, rsp_result, rsp_cnzv, alu_use_pc, alu_use_immediate,
             alu_a, alu_program_counter, alu_b, alu_immediate, alu_operation
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Operands are registered and held for EXEC_CYCLES cycles before the result is captured.
module alu_arbiter #(
   parameter int EXEC_CYCLES = 1
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t     state;
   logic       owner;
   logic       last_grant;
   logic       grant;
   logic       accept;
   logic [1:0] cnt;
   always_comb begin
      grant  = &bus.req_valid ? ~last_grant : bus.req_valid[1];
      accept = rst_n && state == IDLE && |bus.req_valid && !bus.flush;
   end
   assign bus.req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rsp_valid = state == RESP ? {owner, ~owner} : 2'b00;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                   <= IDLE;
         owner                   <= 1'b0;
         last_grant              <= 1'b1;
         cnt                     <= 2'd0;
         bus.rsp_result          <= 32'd0;
         bus.rsp_cnzv            <= 4'd0;
         bus.alu_use_pc          <= 1'b0;
         bus.alu_use_immediate   <= 1'b0;
         bus.alu_a               <= 32'd0;
         bus.alu_program_counter <= 32'd0;
         bus.alu_b               <= 32'd0;
         bus.alu_immediate       <= 32'd0;
         bus.alu_operation       <= 5'd0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               state                   <= EXEC;
               owner                   <= grant;
               last_grant              <= grant;
               cnt                     <= 2'd0;
               bus.alu_use_pc          <= bus.req_use_pc[grant];
               bus.alu_use_immediate   <= bus.req_use_immediate[grant];
               bus.alu_a               <= grant ? bus.req_a[63:32] : bus.req_a[31:0];
               bus.alu_program_counter <= grant ? bus.req_pc[63:32] : bus.req_pc[31:0];
               bus.alu_b               <= grant ? bus.req_b[63:32] : bus.req_b[31:0];
               bus.alu_immediate       <= grant ? bus.req_immediate[63:32] : bus.req_immediate[31:0];
               bus.alu_operation       <= grant ? bus.req_operation[9:5] : bus.req_operation[4:0];
            end
            EXEC: if (bus.flush) begin
               state <= IDLE;
            end else if (cnt == 2'(EXEC_CYCLES - 1)) begin
               state          <= RESP;
               bus.rsp_result <= bus.alu_result;
               bus.rsp_cnzv   <= bus.alu_cnzv;
            end else begin
               cnt <= cnt + 2'd1;
            end
            RESP: if (bus.flush || bus.rsp_ready[owner]) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven and directed checks of alu_arbiter with a behavioural ALU
// (op 0 add, op 16 sub with borrow as carry, op 8 multiply) behind each instance.
module tb_alu_arbiter;
   typedef struct {
      int          who;
      logic        use_pc;
      logic [31:0] a;
      logic [31:0] pc;
      logic        use_imm;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  op;
      logic [31:0] res;
      logic [3:0]  cnzv;
   } vec_t;
   typedef struct {
      logic [1:0]  vld;
      logic [31:0] res;
      logic [3:0]  cnzv;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int tests = 0;
   int fails = 0;
   exp_t sb[$];
   vec_t tbl[7];
   always #5 clk = ~clk;
   alu_arbiter_if if1();
   alu_arbiter_if if3();
   alu_arbiter #(.EXEC_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   alu_arbiter #(.EXEC_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
   function automatic logic [35:0] alu_f(logic up, logic [31:0] a, logic [31:0] pc, logic ui,
                                         logic [31:0] b, logic [31:0] imm, logic [4:0] op);
      logic [31:0] s1, s2, r;
      logic [32:0] t;
      logic c, v;
      s1 = up ? pc : a;
      s2 = ui ? imm : b;
      r = 32'd0;
      c = 1'b0;
      v = 1'b0;
      if (op == 5'd0) begin
         t = {1'b0, s1} + {1'b0, s2};
         r = t[31:0];
         c = t[32];
         v = (s1[31] == s2[31]) && (r[31] != s1[31]);
      end else if (op == 5'd16) begin
         r = s1 - s2;
         c = s1 < s2;
         v = (s1[31] != s2[31]) && (r[31] != s1[31]);
      end else if (op == 5'd8) begin
         r = s1 * s2;
      end
      return {v, r == 32'd0, r[31], c, r};
   endfunction
   always_comb {if1.alu_cnzv, if1.alu_result} = alu_f(if1.alu_use_pc, if1.alu_a, if1.alu_program_counter,
      if1.alu_use_immediate, if1.alu_b, if1.alu_immediate, if1.alu_operation);
   always_comb {if3.alu_cnzv, if3.alu_result} = alu_f(if3.alu_use_pc, if3.alu_a, if3.alu_program_counter,
      if3.alu_use_immediate, if3.alu_b, if3.alu_immediate, if3.alu_operation);
   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [63:0] pk(int who, logic [31:0] x);
      return who == 1 ? {x, 32'd0} : {32'd0, x};
   endfunction
   task automatic clear1();
      if1.req_valid = 2'b00;
      if1.req_use_pc = 2'b00;
      if1.req_use_immediate = 2'b00;
      if1.req_a = 64'd0;
      if1.req_pc = 64'd0;
      if1.req_b = 64'd0;
      if1.req_immediate = 64'd0;
      if1.req_operation = 10'd0;
   endtask
   task automatic clear3();
      if3.req_valid = 2'b00;
      if3.req_use_pc = 2'b00;
      if3.req_use_immediate = 2'b00;
      if3.req_a = 64'd0;
      if3.req_pc = 64'd0;
      if3.req_b = 64'd0;
      if3.req_immediate = 64'd0;
      if3.req_operation = 10'd0;
   endtask
   task automatic drive1(vec_t v);
      if1.req_valid = v.who == 1 ? 2'b10 : 2'b01;
      if1.req_use_pc = v.who == 1 ? {v.use_pc, 1'b0} : {1'b0, v.use_pc};
      if1.req_use_immediate = v.who == 1 ? {v.use_imm, 1'b0} : {1'b0, v.use_imm};
      if1.req_a = pk(v.who, v.a);
      if1.req_pc = pk(v.who, v.pc);
      if1.req_b = pk(v.who, v.b);
      if1.req_immediate = pk(v.who, v.imm);
      if1.req_operation = v.who == 1 ? {v.op, 5'd0} : {5'd0, v.op};
   endtask
   task automatic pop_chk(string nm);
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL %s: scoreboard empty, got rsp_valid %b expected a queued entry", nm, if1.rsp_valid);
      end else begin
         e = sb.pop_front();
         chk({nm, "_valid"}, 64'(if1.rsp_valid), 64'(e.vld));
         chk({nm, "_result"}, 64'(if1.rsp_result), 64'(e.res));
         chk({nm, "_cnzv"}, 64'(if1.rsp_cnzv), 64'(e.cnzv));
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end
   initial begin
      int cyc;
      logic seen;
      vec_t v;
      tbl[0] = '{0, 1'b0, 32'd5, 32'd0, 1'b0, 32'd7, 32'd0, 5'd0, 32'd12, 4'b0000};
      tbl[1] = '{1, 1'b1, 32'hdead, 32'h100, 1'b1, 32'd99, 32'd4, 5'd0, 32'h104, 4'b0000};
      tbl[2] = '{0, 1'b0, 32'h7fffffff, 32'd0, 1'b0, 32'd1, 32'd0, 5'd0, 32'h80000000, 4'b1010};
      tbl[3] = '{1, 1'b0, 32'd3, 32'd0, 1'b0, 32'd3, 32'd0, 5'd16, 32'd0, 4'b0100};
      tbl[4] = '{0, 1'b0, 32'd1, 32'd0, 1'b0, 32'd2, 32'd0, 5'd16, 32'hffffffff, 4'b0011};
      tbl[5] = '{0, 1'b0, 32'hffffffff, 32'd0, 1'b0, 32'd1, 32'd0, 5'd0, 32'd0, 4'b0101};
      tbl[6] = '{1, 1'b0, 32'd2, 32'd0, 1'b0, 32'd3, 32'd0, 5'd8, 32'd6, 4'b0000};
      clear1();
      clear3();
      if1.rsp_ready = 2'b00;
      if3.rsp_ready = 2'b00;
      if1.flush = 1'b0;
      if3.flush = 1'b0;
      repeat (2) tick();
      if1.req_valid = 2'b01;
      #1;
      chk("rst_req_ready", 64'(if1.req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(if1.rsp_valid), 64'd0);
      chk("rst_alu_a", 64'(if1.alu_a), 64'd0);
      chk("rst_alu_op", 64'(if1.alu_operation), 64'd0);
      chk("rst_rsp_result", 64'(if1.rsp_result), 64'd0);
      chk("rst_rsp_cnzv", 64'(if1.rsp_cnzv), 64'd0);
      clear1();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         v = tbl[i];
         drive1(v);
         #1;
         chk("vec_req_ready", 64'(if1.req_ready), v.who == 1 ? 64'd2 : 64'd1);
         sb.push_back('{v.who == 1 ? 2'b10 : 2'b01, v.res, v.cnzv});
         tick();
         clear1();
         chk("vec_alu_op", 64'(if1.alu_operation), 64'(v.op));
         chk("vec_alu_pc", 64'(if1.alu_program_counter), 64'(v.pc));
         chk("vec_alu_use_pc", 64'(if1.alu_use_pc), 64'(v.use_pc));
         chk("vec_alu_use_imm", 64'(if1.alu_use_immediate), 64'(v.use_imm));
         chk("vec_alu_a", 64'(if1.alu_a), 64'(v.a));
         cyc = 1;
         while (if1.rsp_valid == 2'b00 && cyc < 20) begin
            tick();
            cyc++;
         end
         chk("vec_latency", 64'(cyc), 64'd2);
         pop_chk("vec");
         if1.rsp_ready = 2'b11;
         tick();
         if1.rsp_ready = 2'b00;
         chk("vec_rsp_drop", 64'(if1.rsp_valid), 64'd0);
      end
      if1.req_valid = 2'b11;
      if1.req_a = {32'd3, 32'd1};
      if1.req_b = {32'd3, 32'd1};
      if1.req_operation = {5'd16, 5'd0};
      #1;
      chk("both_first_grant", 64'(if1.req_ready), 64'd1);
      sb.push_back('{2'b01, 32'd2, 4'b0000});
      tick();
      chk("both_exec_ready", 64'(if1.req_ready), 64'd0);
      tick();
      pop_chk("both0");
      repeat (5) begin
         tick();
         chk("bp_rsp_valid", 64'(if1.rsp_valid), 64'd1);
         chk("bp_rsp_result", 64'(if1.rsp_result), 64'd2);
         chk("bp_rsp_cnzv", 64'(if1.rsp_cnzv), 64'd0);
         chk("bp_req_ready", 64'(if1.req_ready), 64'd0);
         chk("bp_alu_a", 64'(if1.alu_a), 64'd1);
         chk("bp_alu_op", 64'(if1.alu_operation), 64'd0);
      end
      if1.rsp_ready = 2'b01;
      tick();
      if1.rsp_ready = 2'b00;
      chk("both_second_grant", 64'(if1.req_ready), 64'd2);
      sb.push_back('{2'b10, 32'd0, 4'b0100});
      tick();
      clear1();
      chk("both_alu_op", 64'(if1.alu_operation), 64'd16);
      tick();
      if1.rsp_ready = 2'b01;
      tick();
      pop_chk("both1");
      if1.rsp_ready = 2'b10;
      tick();
      if1.rsp_ready = 2'b00;
      chk("both1_drop", 64'(if1.rsp_valid), 64'd0);
      drive1(tbl[0]);
      tick();
      clear1();
      tick();
      chk("rst_pre_valid", 64'(if1.rsp_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rsp_valid", 64'(if1.rsp_valid), 64'd0);
      chk("arst_alu_a", 64'(if1.alu_a), 64'd0);
      chk("arst_alu_b", 64'(if1.alu_b), 64'd0);
      chk("arst_rsp_result", 64'(if1.rsp_result), 64'd0);
      if1.req_valid = 2'b11;
      #1;
      chk("arst_req_ready", 64'(if1.req_ready), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_grant", 64'(if1.req_ready), 64'd1);
      if1.rsp_ready = 2'b11;
      for (int k = 0; k < 4; k++) begin
         cyc = 0;
         while (if1.req_ready == 2'b00 && cyc < 10) begin
            tick();
            cyc++;
         end
         chk("fair_grant", 64'(if1.req_ready), k % 2 == 1 ? 64'd2 : 64'd1);
         tick();
      end
      clear1();
      repeat (4) tick();
      if1.rsp_ready = 2'b00;
      if3.req_valid = 2'b01;
      if3.req_a = 64'd9;
      if3.req_b = 64'd9;
      #1;
      chk("e3_req_ready", 64'(if3.req_ready), 64'd1);
      tick();
      clear3();
      tick();
      if3.flush = 1'b1;
      tick();
      if3.flush = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         seen = seen | (|if3.rsp_valid);
         tick();
      end
      chk("e3_flush_no_rsp", 64'(seen), 64'd0);
      if3.req_valid = 2'b01;
      if3.req_a = 64'd2;
      if3.req_b = 64'd3;
      if3.req_operation = 10'd8;
      if3.flush = 1'b1;
      #1;
      chk("e3_flush_idle_ready", 64'(if3.req_ready), 64'd0);
      tick();
      if3.flush = 1'b0;
      #1;
      chk("e3_flush_idle_no_accept", 64'(if3.alu_a), 64'd9);
      chk("e3_req_ready2", 64'(if3.req_ready), 64'd1);
      tick();
      clear3();
      cyc = 1;
      while (if3.rsp_valid == 2'b00 && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("e3_latency", 64'(cyc), 64'd4);
      chk("e3_rsp_valid", 64'(if3.rsp_valid), 64'd1);
      chk("e3_rsp_result", 64'(if3.rsp_result), 64'd6);
      if3.flush = 1'b1;
      tick();
      if3.flush = 1'b0;
      chk("e3_resp_flush", 64'(if3.rsp_valid), 64'd0);
      if3.req_valid = 2'b11;
      #1;
      chk("e3_lastgrant_kept", 64'(if3.req_ready), 64'd2);
      clear3();
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters: requester 0 is the core execute stage, requester 1 is the debug/coprocessor port.
- Round-robin arbitration, a valid/ready request channel and a valid/ready response channel per requester.
- Granted operands are registered and held on the ALU for EXEC_CYCLES cycles, so slow multiply paths meet timing.
- ALU result and flags (cnzv: [0] carry, [1] negative, [2] zero, [3] overflow) are captured into a response register.

Parameters:
EXEC_CYCLES, 1, cycles the ALU inputs are held before result capture; legal range 1..4.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  bit i: requester i presents an operation
req_ready  out  2  bit i: requester i accepted this cycle
req_use_pc  in  2  bit i: select pc as source1
req_a  in  64  register operand a, requester i at [32i+31:32i]
req_pc  in  64  program counter, same packing
req_use_immediate  in  2  bit i: select immediate as source2
req_b  in  64  register operand b, same packing
req_immediate  in  64  immediate, same packing
req_operation  in  10  5-bit ALU opcode, requester i at [5i+4:5i]
rsp_valid  out  2  one-hot: response for requester i available
rsp_ready  in  2  bit i: requester i consumes its response
rsp_result  out  32  captured ALU result, qualified by rsp_valid
rsp_cnzv  out  4  captured ALU flags
flush  in  1  synchronous abort of the in-flight operation
alu_use_pc, alu_use_immediate  out  1 each  to ALU
alu_a, alu_program_counter, alu_b, alu_immediate  out  32 each  to ALU
alu_operation  out  5  to ALU
alu_result  in  32  from ALU
alu_cnzv  in  4  from ALU

Behaviour:
- Reset: state=IDLE, owner=0, last_grant=1, exec counter=0; all alu_* outputs, rsp_result and rsp_cnzv zero; rsp_valid=0, req_ready=0.
- Reset is asynchronous: asserting rst_n mid-EXEC or mid-RESP forces reset values immediately; the in-flight operation is lost and no response is issued.
- States:
  - IDLE -> EXEC on any req_valid.
  - EXEC -> RESP after EXEC_CYCLES cycles.
  - RESP -> IDLE on rsp_ready[owner].
- IDLE, grant selection:
  - Only requester i valid: grant i.
  - Both valid: grant the requester not equal to last_grant.
  - req_ready is one-hot on the grant, combinational from req_valid, and only ever asserted in IDLE.
  - Never assert req_ready without the matching req_valid.
- Accept edge:
  - Capture the granted requester's 7 fields into the alu_* output registers.
  - owner := grant, last_grant := grant, counter := 0.
- alu_* outputs come only from registers and change only at an accept edge. In IDLE and RESP they hold the last captured values; they are never combinational from req_*.
- Opcode pass-through: alu_operation is forwarded unmodified. Immediate remapping and unsupported-code handling belong to the ALU.
- EXEC:
  - The counter increments each cycle.
  - On the cycle where counter==EXEC_CYCLES-1, capture alu_result and alu_cnzv into rsp_result and rsp_cnzv at the edge, and enter RESP.
  - Latency: accept in cycle 0, EXEC in cycles 1..EXEC_CYCLES, rsp_valid high from cycle EXEC_CYCLES+1.
- RESP:
  - rsp_valid[owner]=1, the other bit 0.
  - rsp_result and rsp_cnzv are stable until the handshake.
  - A handshake on rsp_ready[owner] returns to IDLE next cycle. rsp_ready of the non-owner is ignored.
  - Minimum occupancy per operation is EXEC_CYCLES+2 cycles.
- flush:
  - In EXEC or RESP: next state IDLE, rsp_valid drops next cycle, no response, last_grant is kept.
  - In IDLE: no effect; flush has priority over a same-cycle accept, so nothing is accepted.
  - In the same cycle as a RESP handshake: treated as a completed handshake.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…; neither starves.

Test Plan:
- Directed bench instantiates the real ALU behind the alu_* ports, with EXEC_CYCLES=1 unless stated.
- Req0 only: a=5, b=7, op=0, rsp_ready=1 -> req_ready=2'b01 in cycle 0; rsp_valid=2'b01 in cycle 2; rsp_result=12, rsp_cnzv=4'b0000.
- Both valid after reset: req0 op=0 a=1 b=1; req1 op=16 a=3 b=3 -> req0 granted first (result 2). Req1 is then granted in the first IDLE cycle after req0's response handshake: rsp_valid=2'b10, rsp_result=0, rsp_cnzv=4'b0100.
- Req1 use_pc=1, pc=0x100, use_immediate=1, immediate=4, op=0 -> alu_program_counter=0x100, alu_use_pc=1, alu_use_immediate=1; rsp_result=0x104.
- Back-pressure: rsp_ready=0 for 5 cycles while req0 and req1 both stay valid -> rsp_valid, rsp_result and rsp_cnzv stable; req_ready=0; alu_* unchanged. After the handshake, req1 is granted.
- EXEC_CYCLES=3: flush in second EXEC cycle -> no rsp_valid pulse; back to IDLE. The next req0 (a=2, b=3, op=8) gives result 6 at cycle 4 after accept.
- rst_n pulsed low during RESP -> rsp_valid=0 and alu_*=0 immediately. The first request after release goes to requester 0 even if both are valid.
